// File: rtl/shift_scheduler.sv
// Arbiter/sequencer that shares one right-logical barrel shifter between two requesters,
// building SLL/SRA (and ROR when SHIFT_ROR_EN is defined) from bit reversal, inversion and two passes.
module shift_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    input  logic [1:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic [31:0] sh_in,
    output logic [31:0] sh_ctrl,
    input  logic [31:0] sh_out
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic logic [31:0] rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    state_t      state, next_state;
    logic [31:0] x_q;
    logic [4:0]  amt_q;
    logic [1:0]  op_q;
    logic        id_q;
    logic [31:0] result_q, result_next;
    logic        last_grant;
    logic        grant0, grant1, accept;
    logic [4:0]  sh_amt;
`ifdef SHIFT_ROR_EN
    logic [31:0] partial_q, partial_next;
`endif

    // last_grant = 1 means port 1 was served last, so port 0 wins the next tie
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
    assign accept = (state == IDLE) & (grant0 | grant1);

    assign req0_ready = (state == IDLE) & grant0 & ~rst;
    assign req1_ready = (state == IDLE) & grant1 & ~rst;
    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_data  = result_q;
    assign sh_ctrl    = {27'd0, sh_amt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            x_q        <= '0;
            amt_q      <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            result_q   <= '0;
`ifdef SHIFT_ROR_EN
            partial_q  <= '0;
`endif
        end else begin
            state    <= next_state;
            result_q <= result_next;
`ifdef SHIFT_ROR_EN
            partial_q <= partial_next;
`endif
            if (accept) begin
                x_q        <= grant1 ? req1_data : req0_data;
                amt_q      <= grant1 ? req1_amt  : req0_amt;
                op_q       <= grant1 ? req1_op   : req0_op;
                id_q       <= grant1;
                last_grant <= grant1;
            end
        end
    end

    // Shifter drive and sequencing; kept apart from the result path so sh_out never feeds sh_in
    always_comb begin
        next_state = state;
        sh_in      = '0;
        sh_amt     = '0;
        case (state)
            IDLE: begin
                if (accept) next_state = PASS1;
            end
            PASS1: begin
                sh_amt     = amt_q;
                next_state = RESP;
                case (op_q)
                    OP_SLL: sh_in = rev(x_q);
                    OP_SRA: sh_in = x_q[31] ? ~x_q : x_q;
`ifdef SHIFT_ROR_EN
                    OP_ROR: begin
                        sh_in = x_q;
                        if (amt_q != 5'd0) next_state = PASS2;
                    end
`endif
                    default: sh_in = x_q;
                endcase
            end
`ifdef SHIFT_ROR_EN
            PASS2: begin
                sh_in      = rev(x_q);
                sh_amt     = 5'd0 - amt_q;
                next_state = RESP;
            end
`endif
            RESP: begin
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        result_next = result_q;
`ifdef SHIFT_ROR_EN
        partial_next = partial_q;
`endif
        case (state)
            PASS1: begin
                case (op_q)
                    OP_SLL: result_next = rev(sh_out);
                    OP_SRA: result_next = x_q[31] ? ~sh_out : sh_out;
`ifdef SHIFT_ROR_EN
                    OP_ROR: begin
                        result_next  = sh_out;
                        partial_next = sh_out;
                    end
`endif
                    default: result_next = sh_out;
                endcase
            end
`ifdef SHIFT_ROR_EN
            PASS2: result_next = partial_q | rev(sh_out);
`endif
            default: result_next = result_q;
        endcase
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler: a monitor pushes model results on each request
// handshake and the directed sequence pops and checks them against the response channel.
module tb_shift_scheduler;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic [1:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data, sh_in, sh_ctrl, sh_out;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          t;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic id_seen;

    shift_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .sh_in(sh_in), .sh_ctrl(sh_ctrl), .sh_out(sh_out)
    );

    // Shared right-logical barrel shifter
    assign sh_out = sh_in >> sh_ctrl[4:0];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a);
        case (op)
            OP_SLL: return d << a;
            OP_SRA: return 32'($signed(d) >>> a);
`ifdef SHIFT_ROR_EN
            OP_ROR: return (a == 5'd0) ? d : ((d >> a) | (d << (32 - int'(a))));
`endif
            default: return d >> a;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [4:0] a);
`ifdef SHIFT_ROR_EN
        if (op == OP_ROR && a != 5'd0) return 3;
`endif
        return 2;
    endfunction

    // Scoreboard producer: record expected result at every request handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready)
                sb.push_back('{id: 1'b0, data: model(req0_op, req0_data, req0_amt), t: cycle, lat: model_lat(req0_op, req0_amt)});
            if (req1_valid && req1_ready)
                sb.push_back('{id: 1'b1, data: model(req1_op, req1_data, req1_amt), t: cycle, lat: model_lat(req1_op, req1_amt)});
        end
    end

    task automatic compare(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        bit seen = 0;
        @(posedge clk); #2;
        if (port) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_op = op;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((port ? req1_ready : req0_ready) === 1'b1) begin
                seen = 1;
                break;
            end
        end
        compare("req_accept", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int hold, output logic id_obs);
        exp_t e;
        bit got = 0;
        resp_ready = (hold == 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        compare({name, "_valid"}, {31'd0, got}, 32'd1);
        id_obs = resp_id;
        if (!got) begin
            resp_ready = 1'b1;
            return;
        end
        compare({name, "_sb_entry"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{id: 1'bx, data: 'x, t: 0, lat: -1};
        compare({name, "_data"}, resp_data, e.data);
        compare({name, "_id"}, {31'd0, resp_id}, {31'd0, e.id});
        compare({name, "_latency"}, cycle - e.t, e.lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            compare({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            compare({name, "_hold_data"}, resp_data, e.data);
            compare({name, "_hold_id"}, {31'd0, resp_id}, {31'd0, e.id});
            compare({name, "_hold_sh_in"}, sh_in, 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #2;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        compare({name, "_after_handshake"}, {31'd0, resp_valid}, 32'd0);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 5'd1; req0_op = OP_SRL;
        req1_valid = 1'b1; req1_data = 32'h2; req1_amt = 5'd1; req1_op = OP_SRL;

        repeat (2) @(negedge clk);
        compare("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        compare("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        compare("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        compare("reset_resp_id", {31'd0, resp_id}, 32'd0);
        compare("reset_resp_data", resp_data, 32'd0);
        compare("reset_sh_in", sh_in, 32'd0);
        compare("reset_sh_ctrl", sh_ctrl, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        applyStimulus(1'b0, 32'h8000_0000, 5'd4, OP_SRL);
        checkOutput("srl", 0, id_seen);
        compare("srl_const", resp_data, 32'h0800_0000);
        applyStimulus(1'b1, 32'h0000_0001, 5'd31, OP_SLL);
        checkOutput("sll", 0, id_seen);
        compare("sll_id_const", {31'd0, id_seen}, 32'd1);
        applyStimulus(1'b0, 32'hF000_0000, 5'd4, OP_SRA);
        checkOutput("sra_neg", 0, id_seen);
        compare("sra_neg_const", resp_data, 32'hFF00_0000);
        applyStimulus(1'b1, 32'h7000_0000, 5'd4, OP_SRA);
        checkOutput("sra_pos", 0, id_seen);
        applyStimulus(1'b0, 32'h8000_0000, 5'd31, OP_SRA);
        checkOutput("sra_max", 0, id_seen);
        compare("sra_max_const", resp_data, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'h0000_0001, 5'd1, OP_ROR);
        checkOutput("ror_1", 0, id_seen);
        applyStimulus(1'b0, 32'h1234_5678, 5'd0, OP_ROR);
        checkOutput("ror_0", 0, id_seen);
        applyStimulus(1'b0, 32'h1234_5678, 5'd8, OP_ROR);
        checkOutput("ror_8", 0, id_seen);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd0, OP_SLL);
        checkOutput("sll_0", 0, id_seen);
        applyStimulus(1'b1, 32'hCAFE_0001, 5'd3, OP_SLL);
        checkOutput("backpressure", 5, id_seen);

        // Fresh pointer, then both ports hammer the shifter
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        req0_valid = 1'b1; req0_data = 32'hA5A5_0F0F; req0_amt = 5'd3; req0_op = OP_SLL;
        req1_valid = 1'b1; req1_data = 32'h8000_1234; req1_amt = 5'd7; req1_op = OP_SRA;
        for (int i = 0; i < 4; i++) begin
            checkOutput("arb", 0, id_seen);
            compare("arb_alternate", {31'd0, id_seen}, i % 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset while a rotate is in flight from port 0
        applyStimulus(1'b0, 32'h0000_0001, 5'd5, OP_ROR);
`ifdef SHIFT_ROR_EN
        @(posedge clk); #2;
`endif
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_amt = 5'd4; req0_op = OP_SRL;
        req1_valid = 1'b1; req1_data = 32'h0000_0F00; req1_amt = 5'd4; req1_op = OP_SRL;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
            compare("midrst_req1_ready", {31'd0, req1_ready}, 32'd0);
            compare("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        compare("postrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        #1;
        checkOutput("postrst", 0, id_seen);
        compare("postrst_first_grant", {31'd0, id_seen}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        repeat (4) @(negedge clk);
        compare("sb_drained", sb.size(), 32'd0);
        compare("idle_sh_ctrl", sh_ctrl, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_scheduler.md
# shift_scheduler

Sequencer and arbiter for the shared 32-bit right-logical barrel shifter in the EX stage. It shares the shifter between two requesters, the ALU shift path (port 0) and the load/store byte-alignment path (port 1). It synthesizes SLL, SRA and optional rotate from the right-only shifter by bit-reversal, inversion and two-pass sequencing. Results are registered and returned over a valid/ready response channel tagged with the requester ID.

## Interface
- No parameters; data width fixed at 32, shift amount fixed at 5 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request pending on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational).
- req0_data / req1_data  in  32  operand.
- req0_amt / req1_amt  in  5  shift amount.
- req0_op / req1_op  in  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_id  out  1  requester that issued the result.
- resp_data  out  32  result.
- sh_in  out  32  operand driven to the shared shifter.
- sh_ctrl  out  32  shift amount to the shifter; bits 31:5 always 0.
- sh_out  in  32  shifter result, combinational from sh_in/sh_ctrl.

## Operation
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE
  - Round-robin arbitration between ports.
  - If only one port is valid, grant it.
  - If both are valid, grant the port not granted last.
  - The last-grant pointer resets to "port 1 last", so port 0 wins first.
  - reqN_ready = (state==IDLE) & grantN & !rst.
  - On handshake, capture data, amt, op and id; go to PASS1.
- PASS1: one shifter pass, result into the result register.
  - SRL: sh_in = x, ctrl = amt, result = sh_out.
  - SLL: sh_in = rev(x), result = rev(sh_out).
  - SRA: if x[31]=0, as SRL; if x[31]=1, sh_in = ~x, result = ~sh_out.
  - ROR: store srl(x, amt) in a partial register.
  - Next state: PASS2 only for ROR with amt != 0; otherwise RESP. ROR with amt = 0 returns x.
- PASS2 (ROR only): sh_in = rev(x), ctrl = (32 - amt) & 31. Result = partial | rev(sh_out). Go to RESP.
- RESP
  - resp_valid = 1; resp_data and resp_id held stable.
  - On resp_valid & resp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle.
- sh_in and sh_ctrl are 0 in IDLE and RESP.
- amt is treated as an unsigned value from 0 to 31. Amount 0 returns the operand unchanged for every op.

## Timing
- Reset values:
  - state IDLE, resp_valid 0, resp_id 0, resp_data 0.
  - sh_in 0, sh_ctrl 0.
  - req0_ready and req1_ready 0 while rst is high.
- Latency (request accepted at edge T):
  - Single-pass ops: resp_valid rises after edge T+2.
  - ROR with amt != 0: resp_valid rises after edge T+3.
- Throughput: at most one operation in flight. The next accept is the cycle after the response handshake.
- Backpressure: resp_ready low holds RESP indefinitely; all outputs stay stable.
- Reset mid-operation: the operation is dropped, no response is issued, and the arbiter pointer returns to its reset value.
- A requester that drops valid before ready is not served. No request is buffered.

## Configuration
- Macro SHIFT_ROR_EN.
- Defined: op 11 performs rotate right using PASS2.
- Undefined:
  - op 11 is executed as SRL.
  - The PASS2 state and partial register are not built.
  - Maximum latency is 2 cycles.

## Test plan
- SRL: req0 data 0x80000000, amt 4 -> resp_data 0x08000000, resp_id 0, resp_valid after edge T+2.
- SLL: req1 data 0x00000001, amt 31 -> 0x80000000, resp_id 1.
- SRA:
  - 0xF0000000 amt 4 -> 0xFF000000.
  - 0x70000000 amt 4 -> 0x07000000.
  - 0x80000000 amt 31 -> 0xFFFFFFFF.
- ROR (SHIFT_ROR_EN):
  - 0x00000001 amt 1 -> 0x80000000 after edge T+3.
  - 0x12345678 amt 0 -> 0x12345678 after edge T+2.
  - Without the macro, 0x00000001 amt 1 -> 0x00000000.
- Arbitration: both ports continuously valid, resp_ready = 1 -> grants alternate 0,1,0,1 starting with 0. Holding resp_ready low for 5 cycles keeps resp_data/resp_id constant.
- Reset: assert rst during PASS2 -> resp_valid stays 0, readies are 0 during reset, and the first grant after release goes to port 0.
